// File: rtl/output_display_pkg.sv
// Shared definitions for the output register display: FSM states, digit
// codes, segment patterns and the double-dabble adjust step.
package output_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Digit codes beyond 0-9
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hB;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // One shift per bit of the 8-bit magnitude
  localparam logic [2:0] DD_LAST_STEP = 3'd7;

  // Add 3 to every BCD digit that is 5 or more (applied before each shift)
  function automatic logic [11:0] bcd_add3(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_display_seven_seg_decoder.sv
// Digit code to active-high 7-segment pattern (0-9, blank, minus).
module seven_seg_decoder
  import output_display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Pure lookup; unknown codes render blank
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:       o_seg = SEG_0;
      4'd1:       o_seg = SEG_1;
      4'd2:       o_seg = SEG_2;
      4'd3:       o_seg = SEG_3;
      4'd4:       o_seg = SEG_4;
      4'd5:       o_seg = SEG_5;
      4'd6:       o_seg = SEG_6;
      4'd7:       o_seg = SEG_7;
      4'd8:       o_seg = SEG_8;
      4'd9:       o_seg = SEG_9;
      CODE_MINUS: o_seg = SEG_MINUS;
      default:    o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/output_display.sv
// Output register of the 8-bit computer: latches the bus on oi&load_strobe,
// converts to BCD with a sequential double-dabble and scans the result onto
// a 4-digit multiplexed 7-segment display.
module output_display
  import output_display_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD   = 50000,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,
  input  logic       oi,
  input  logic       load_strobe,
  input  logic       signed_mode,
  output logic [7:0] value,
  output logic       busy,
  output logic [7:0] io_seg,
  output logic [3:0] io_sel
);

  localparam int unsigned   CW        = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [7:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]    SEL_OFF   = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  state_t        r_state, w_next;
  logic          w_load;
  logic          w_busy;
  logic [7:0]    r_value;
  logic [7:0]    w_mag;
  logic [7:0]    r_mag;
  logic          r_neg;
  logic [11:0]   r_scratch;
  logic [11:0]   w_adj;
  logic [2:0]    r_step;
  logic [3:0]    r_d0, r_d1, r_d2, r_d3;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_idx;
  logic [3:0]    w_code;
  logic [6:0]    w_pat;
  logic [3:0]    w_onehot;
  logic [7:0]    r_seg;
  logic [3:0]    r_sel;

  assign w_load = oi & load_strobe;
  assign w_mag  = (signed_mode & bus[7]) ? (~bus + 8'd1) : bus;
  assign w_adj  = bcd_add3(r_scratch);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: a load always (re)starts the conversion, latest wins
  always_comb begin
    w_next = r_state;
    if (w_load) begin
      w_next = ST_CONVERT;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = ST_IDLE;
        ST_CONVERT: if (r_step == DD_LAST_STEP) w_next = ST_COMMIT;
        ST_COMMIT:  w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_CONVERT, ST_COMMIT: w_busy = 1'b1;
      default:               w_busy = 1'b0;
    endcase
  end

  // Value latch, double-dabble datapath and committed display digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= '0;
      r_mag     <= '0;
      r_neg     <= 1'b0;
      r_scratch <= '0;
      r_step    <= '0;
      r_d0      <= 4'd0;
      r_d1      <= CODE_BLANK;
      r_d2      <= CODE_BLANK;
      r_d3      <= CODE_BLANK;
    end else if (w_load) begin
      r_value   <= bus;
      r_mag     <= w_mag;
      r_neg     <= signed_mode & bus[7];
      r_scratch <= '0;
      r_step    <= '0;
    end else if (r_state == ST_CONVERT) begin
      r_scratch <= {w_adj[10:0], r_mag[7]};
      r_mag     <= {r_mag[6:0], 1'b0};
      r_step    <= r_step + 3'd1;
    end else if (r_state == ST_COMMIT) begin
      // Leading-zero blanking is resolved here so the scan path stays a plain mux
      r_d0 <= r_scratch[3:0];
      r_d1 <= (r_scratch[11:4] == 8'd0) ? CODE_BLANK : r_scratch[7:4];
      r_d2 <= (r_scratch[11:8] == 4'd0) ? CODE_BLANK : r_scratch[11:8];
      r_d3 <= r_neg ? CODE_MINUS : CODE_BLANK;
    end
  end

  // Refresh counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (r_refresh == CNT_LAST) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Selected digit code
  always_comb begin
    w_code = CODE_BLANK;
    case (r_idx)
      2'd0: w_code = r_d0;
      2'd1: w_code = r_d1;
      2'd2: w_code = r_d2;
      2'd3: w_code = r_d3;
      default: w_code = CODE_BLANK;
    endcase
  end

  seven_seg_decoder u_dec (
    .i_code (w_code),
    .o_seg  (w_pat)
  );

  assign w_onehot = 4'b0001 << r_idx;

  // Registered, polarity-adjusted display drive; blanked at each slot start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
    end else begin
      r_sel <= SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
      if (r_refresh < CNT_BLANK) r_seg <= SEG_OFF;
      else                       r_seg <= SEG_ACTIVE_LOW ? ~{1'b0, w_pat} : {1'b0, w_pat};
    end
  end

  assign value  = r_value;
  assign busy   = w_busy;
  assign io_seg = r_seg;
  assign io_sel = r_sel;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display: stimulus pushes the expected commit,
// a monitor pops it on each busy fall and reads the scanned display back.
module tb_output_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus = '0;
  logic       oi = 1'b0;
  logic       load_strobe = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] value;
  logic       busy;
  logic [7:0] io_seg;
  logic [3:0] io_sel;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    int unsigned id;
    logic [7:0]  value;
    int unsigned busy_len;
    logic [31:0] segs;
  } exp_t;

  exp_t sb[$];

  output_display #(
    .DIGIT_PERIOD   (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .oi          (oi),
    .load_strobe (load_strobe),
    .signed_mode (signed_mode),
    .value       (value),
    .busy        (busy),
    .io_seg      (io_seg),
    .io_sel      (io_sel)
  );

  always #5 clk = ~clk;

  // Active-low io_seg value expected for one display character
  function automatic logic [7:0] exp_seg(input byte c);
    logic [6:0] p;
    case (c)
      "0": p = 7'h3F;  "1": p = 7'h06;  "2": p = 7'h5B;  "3": p = 7'h4F;
      "4": p = 7'h66;  "5": p = 7'h6D;  "6": p = 7'h7D;  "7": p = 7'h07;
      "8": p = 7'h7F;  "9": p = 7'h6F;  "-": p = 7'h40;
      default: p = 7'h00;
    endcase
    return ~{1'b0, p};
  endfunction

  // Four characters, leftmost = d3, packed {d3,d2,d1,d0}
  function automatic logic [31:0] exp_disp(input string s);
    return {exp_seg(s[0]), exp_seg(s[1]), exp_seg(s[2]), exp_seg(s[3])};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read the display off the scan: keep each digit's segments from slot positions >= 2
  task automatic capture(output logic [31:0] segs);
    logic [3:0]  last_sel;
    logic [3:0]  onehot;
    int unsigned run;
    segs     = '0;
    last_sel = 4'hF;
    run      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io_sel == last_sel) run++;
      else begin
        run      = 0;
        last_sel = io_sel;
      end
      if (run >= 2) begin
        for (int k = 0; k < 4; k++) begin
          onehot = 4'b0001 << k;
          if (io_sel == ~onehot) segs[k*8 +: 8] = io_seg;
        end
      end
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic o, input logic s, input logic sm);
    bus         = b;
    oi          = o;
    load_strobe = s;
    signed_mode = sm;
    @(posedge clk);
    @(negedge clk);
    oi          = 1'b0;
    load_strobe = 1'b0;
  endtask

  task automatic expect_commit(input int unsigned id, input logic [7:0] v,
                               input int unsigned len, input string disp);
    exp_t e;
    e.id       = id;
    e.value    = v;
    e.busy_len = len;
    e.segs     = exp_disp(disp);
    sb.push_back(e);
  endtask

  // Monitor: a busy falling edge means a conversion committed
  initial begin : monitor
    logic        prev;
    int unsigned len;
    logic [31:0] segs;
    exp_t        e;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (busy) len++;
      if (prev && !busy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_commit: got value %h expected no commit", value);
        end else begin
          e = sb.pop_front();
          check($sformatf("value_%0d", e.id), {24'd0, value}, {24'd0, e.value});
          check($sformatf("busy_len_%0d", e.id), len, e.busy_len);
          capture(segs);
          check($sformatf("display_%0d", e.id), segs, e.segs);
        end
        len = 0;
      end
      prev = busy;
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] segs;
    logic        saw_busy;
    logic [3:0]  onehot;
    int unsigned p, idx;
    string       boot;
    boot = "   0";

    // Reset pulse mid-scan: outputs go inactive asynchronously
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (13) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_seg_async", {24'd0, io_seg}, 32'h0000_00FF);
    check("rst_sel_async", {28'd0, io_sel}, 32'h0000_000F);
    @(negedge clk);
    rst = 1'b0;
    check("rst_value", {24'd0, value}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Scan sequence right after release, showing "   0"
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      p      = (n - 1) % 8;
      idx    = ((n - 1) / 8) % 4;
      onehot = 4'b0001 << idx;
      check($sformatf("scan_sel_%0d", n), {28'd0, io_sel}, {28'd0, ~onehot});
      check($sformatf("scan_seg_%0d", n), {24'd0, io_seg},
            {24'd0, (p < 2) ? 8'hFF : exp_seg(boot[3 - idx])});
    end

    // Directed conversions
    expect_commit(1, 8'hAD, 9, " 173");
    drive(8'd173, 1'b1, 1'b1, 1'b0);
    repeat (60) @(negedge clk);

    expect_commit(2, 8'h80, 9, "-128");
    drive(8'h80, 1'b1, 1'b1, 1'b1);
    signed_mode = 1'b0;  // must not affect the running conversion
    repeat (60) @(negedge clk);

    expect_commit(3, 8'hFF, 9, "-  1");
    drive(8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (60) @(negedge clk);

    expect_commit(4, 8'h05, 9, "   5");
    drive(8'h05, 1'b1, 1'b1, 1'b1);
    repeat (60) @(negedge clk);

    // oi alone / strobe alone: no load
    saw_busy = 1'b0;
    drive(8'h42, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    drive(8'h42, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("noload_busy", {31'd0, saw_busy}, 32'd0);
    check("noload_value", {24'd0, value}, 32'h05);
    capture(segs);
    check("noload_display", segs, exp_disp("   5"));

    // Reload while busy: only the latest value is ever committed
    expect_commit(5, 8'd250, 13, " 250");
    drive(8'd9, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    drive(8'd250, 1'b1, 1'b1, 1'b0);
    repeat (70) @(negedge clk);

    expect_commit(6, 8'd100, 9, " 100");
    drive(8'd100, 1'b1, 1'b1, 1'b0);
    repeat (60) @(negedge clk);

    expect_commit(7, 8'h7F, 9, " 127");
    drive(8'h7F, 1'b1, 1'b1, 1'b1);
    repeat (60) @(negedge clk);

    expect_commit(8, 8'hFF, 9, " 255");
    drive(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (60) @(negedge clk);

    expect_commit(9, 8'h00, 9, "   0");
    drive(8'h00, 1'b1, 1'b1, 1'b1);
    repeat (60) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
